seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side companion to the BCD-to-7-segment encoder. It monitors a time-multiplexed, common-anode 4-digit display bus (segment lines plus active-low digit anodes).
- It waits for each digit to settle, decodes the segment pattern back to a hex nibble and assembles a full frame in digit order.
- Each completed frame is presented as one word with a one-cycle valid strobe.
- Used as a self-check monitor on scan-driver outputs and as a readback path for display-driven designs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high, bit order {a,b,c,d,e,f,g} (seg[6]=a, seg[0]=g), synchronous to clk.
- an  input  NUM_DIGITS  digit enables, active-low one-hot; an[0] = digit 0 = least-significant nibble.
- value  output  4*NUM_DIGITS  last completed frame, digit i in value[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when value is updated.
- digit_err  output  NUM_DIGITS  per-digit flag for an unrecognised segment pattern in the last completed frame.
- frame_abort  output  1  one-cycle pulse when an in-progress frame is discarded.

Behaviour:
- Reset values (async, rst_n=0): value=0, frame_valid=0, digit_err=0, frame_abort=0, sample register=0, run counter=0, FSM=IDLE, shadow frame=0.
- Input stage: {an,seg} is registered every edge, with no synchroniser since inputs are in the clk domain.
  - The run counter resets to 1 when the new sample differs from the previous sample.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Capture event: fires exactly once per stable run, on the edge at which the counter reaches STABLE_CYCLES. With STABLE_CYCLES=1, every changed sample captures.
  - Timing: if pins become constant before edge E0, the capture is acted on at edge E0+STABLE_CYCLES.
- Capture classification:
  - an all-ones (blank): ignored, no state change.
  - an not exactly one bit low (multi-hot or all-zero): invalid. Treated as out-of-order (see below).
  - an one-hot-low with index k: decode seg.
- Decode table (hex -> seg): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. Any other pattern gives nibble 0 and sets the shadow error bit for digit k.
- FSM:
  - IDLE: a capture with k=0 stores digit 0, sets expect=1, and moves to COLLECT. Other captures are ignored.
  - COLLECT, k==expect:
    - Store the digit and increment expect.
    - If k==NUM_DIGITS-1: copy shadow to value and digit_err, pulse frame_valid, clear the shadow, go to IDLE. The pulse is high in the cycle after that edge.
  - COLLECT, k!=expect or invalid an:
    - Pulse frame_abort and clear the shadow.
    - If k==0, restart the frame (store digit 0, expect=1, stay in COLLECT); otherwise go to IDLE.
  - Same anode re-captured with changed seg: counts as k!=expect and aborts.
- value and digit_err hold between frames. They change only on frame completion.
- frame_valid and frame_abort are never high in the same cycle.
- Reset mid-frame discards the partial frame. No frame_valid follows reset until a full 0..N-1 sequence is seen.
- A glitch shorter than STABLE_CYCLES produces no capture.
  - Run counter saturation means a steady digit never re-captures.
  - A digit interrupted by a glitch and then resumed produces a second capture, which aborts the frame.

Decomposition:
- seg7_pkg holds:
  - segment bit-order constants;
  - SEG_HEX_0..SEG_HEX_F pattern constants, shared with the encoder;
  - the FSM state encoding (IDLE, COLLECT).
- Sub-module seg7_to_hex: combinational, seg[6:0] -> hex[3:0] plus valid. Instantiated once on the sampled seg.

Test Plan:
- STABLE_CYCLES=4, scan an=E,D,B,7 with seg=30,6D,79,33, each held 8 cycles -> one frame_valid, value=16'h4321, digit_err=0.
- Same scan, but digit 2 shows 3-cycle seg=7F then 79 held 8 cycles -> value=16'h4321 (glitch ignored), no abort.
- Digit 1 seg=00 (blank pattern) in an otherwise valid scan -> value=16'h4301, digit_err=4'b0010.
- Order 0,2,1,3 (an=E,B,D,7) -> frame_abort at digit 2, no frame_valid. A following proper scan yields its value.
- an=4'b1100 held 8 cycles mid-frame -> frame_abort. an=F for 20 cycles mid-frame -> no abort, and the frame completes afterward.
- rst_n low for 2 cycles after digit 2 is captured -> all outputs 0 immediately. Resuming with digit 3 gives no frame_valid; the next full scan completes normally.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment encoder/decoder pair.
//   - segment bit positions within a {a,b,c,d,e,f,g} bus (a = MSB)
//   - SEG_HEX_0..SEG_HEX_F active-high glyph patterns
//   - scan decoder FSM state encoding
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h47;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display bus plus decoded-frame outputs.
//   seg         - segment lines {a..g}, active-high
//   an          - digit enables, active-low one-hot
//   value       - last completed frame, digit i in value[4i+3:4i]
//   frame_valid - one-cycle strobe when value updates
//   digit_err   - per-digit unrecognised-pattern flags of last frame
//   frame_abort - one-cycle strobe when a partial frame is dropped
// master: display side / observer. slave: the scan decoder.
interface seg7_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    frame_valid;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_abort;

    modport master (
        output seg, an,
        input  value, frame_valid, digit_err, frame_abort
    );

    modport slave (
        input  seg, an,
        output value, frame_valid, digit_err, frame_abort
    );
endinterface

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational 7-segment pattern to hex nibble decoder.
//   seg   - pattern {a,b,c,d,e,f,g}, active-high
//   hex   - decoded nibble (0 for unrecognised patterns)
//   valid - 1 when seg matches one of the 16 glyphs
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       hex,
    output logic             valid
);

    always_comb begin
        hex   = '0;
        valid = 1'b1;
        case (seg)
            SEG_HEX_0: hex = 4'h0;
            SEG_HEX_1: hex = 4'h1;
            SEG_HEX_2: hex = 4'h2;
            SEG_HEX_3: hex = 4'h3;
            SEG_HEX_4: hex = 4'h4;
            SEG_HEX_5: hex = 4'h5;
            SEG_HEX_6: hex = 4'h6;
            SEG_HEX_7: hex = 4'h7;
            SEG_HEX_8: hex = 4'h8;
            SEG_HEX_9: hex = 4'h9;
            SEG_HEX_A: hex = 4'hA;
            SEG_HEX_B: hex = 4'hB;
            SEG_HEX_C: hex = 4'hC;
            SEG_HEX_D: hex = 4'hD;
            SEG_HEX_E: hex = 4'hE;
            SEG_HEX_F: hex = 4'hF;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a multiplexed common-anode display bus,
// waits for each digit to settle, decodes it and assembles frames in
// digit order 0..NUM_DIGITS-1.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave modport: seg/an in; value, frame_valid, digit_err,
//           frame_abort out
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int unsigned SW  = NUM_DIGITS + SEG_W;
    localparam int unsigned CW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned EW  = $clog2(NUM_DIGITS);
    localparam int unsigned LCW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned VW  = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [EW-1:0] LAST_K  = EW'(NUM_DIGITS - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic [CW-1:0]   run_q, run_d;
    logic            capture_q, capture_d;
    logic [EW-1:0]   expect_q, expect_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_err_q, shadow_err_d;
    logic [VW-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0] digit_err_q, digit_err_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_abort_q, frame_abort_d;

    logic [SW-1:0]   pins;
    logic            changed;
    logic [NUM_DIGITS-1:0] an_s;
    logic [SEG_W-1:0] seg_s;
    logic [LCW-1:0]  low_cnt;
    logic [EW-1:0]   k;
    logic            blank;
    logic            cap_digit;
    logic            cap_bad;
    logic [3:0]      hex;
    logic            hex_ok;
    logic [VW-1:0]   shadow_ins, shadow_fresh;
    logic [NUM_DIGITS-1:0] err_ins, err_fresh;

    assign pins = {bus.an, bus.seg};

    // Input stage. The capture is registered so the FSM acts on it one
    // edge later, using the still-stable sample.
    always_comb begin
        changed  = (pins != sample_q);
        sample_d = pins;
        if (changed) begin
            run_d = CW'(1);
        end else if (run_q != CNT_MAX) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end
        capture_d = (run_d == CNT_MAX) && (changed || (run_q != CNT_MAX));
    end

    // Classification of the sampled anodes.
    always_comb begin
        an_s  = sample_q[SW-1 -: NUM_DIGITS];
        seg_s = {sample_q[SEG_A], sample_q[SEG_B], sample_q[SEG_C],
                 sample_q[SEG_D], sample_q[SEG_E], sample_q[SEG_F],
                 sample_q[SEG_G]};
        low_cnt = '0;
        k       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + 1'b1;
                k       = EW'(i);
            end
        end
        blank     = &an_s;
        cap_digit = capture_q && (low_cnt == LCW'(1));
        cap_bad   = capture_q && !blank && (low_cnt != LCW'(1));
    end

    seg7_to_hex u_to_hex (
        .seg   (seg_s),
        .hex   (hex),
        .valid (hex_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sample_q      <= '0;
            run_q         <= '0;
            capture_q     <= 1'b0;
            expect_q      <= '0;
            shadow_q      <= '0;
            shadow_err_q  <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            run_q         <= run_d;
            capture_q     <= capture_d;
            expect_q      <= expect_d;
            shadow_q      <= shadow_d;
            shadow_err_q  <= shadow_err_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_digit && (k == '0)) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cap_digit && (k == expect_q)) begin
                    if (k == LAST_K) begin
                        state_d = ST_IDLE;
                    end
                end else if (cap_digit && (k == '0)) begin
                    state_d = ST_COLLECT;
                end else if (cap_digit || cap_bad) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shadow_ins            = shadow_q;
        shadow_ins[{k, 2'b00} +: 4] = hex;
        err_ins               = shadow_err_q;
        err_ins[k]            = !hex_ok;
        shadow_fresh          = '0;
        shadow_fresh[3:0]     = hex;
        err_fresh             = '0;
        err_fresh[0]          = !hex_ok;

        shadow_d      = shadow_q;
        shadow_err_d  = shadow_err_q;
        expect_d      = expect_q;
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        frame_valid_d = 1'b0;
        frame_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cap_digit && (k == '0)) begin
                    shadow_d     = shadow_fresh;
                    shadow_err_d = err_fresh;
                    expect_d     = EW'(1);
                end
            end
            ST_COLLECT: begin
                if (cap_digit && (k == expect_q)) begin
                    if (k == LAST_K) begin
                        value_d       = shadow_ins;
                        digit_err_d   = err_ins;
                        frame_valid_d = 1'b1;
                        shadow_d      = '0;
                        shadow_err_d  = '0;
                        expect_d      = '0;
                    end else begin
                        shadow_d     = shadow_ins;
                        shadow_err_d = err_ins;
                        expect_d     = expect_q + 1'b1;
                    end
                end else if (cap_digit || cap_bad) begin
                    frame_abort_d = 1'b1;
                    if (cap_digit && (k == '0)) begin
                        shadow_d     = shadow_fresh;
                        shadow_err_d = err_fresh;
                        expect_d     = EW'(1);
                    end else begin
                        shadow_d     = '0;
                        shadow_err_d = '0;
                        expect_d     = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.value       = value_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   vcnt  = 0;
    int   acnt  = 0;
    int   both_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.frame_valid) vcnt++;
        if (bus.frame_abort) acnt++;
        if (bus.frame_valid && bus.frame_abort) both_cnt++;
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'hE, s0, 8);
        drive(4'hD, s1, 8);
        drive(4'hB, s2, 8);
        drive(4'h7, s3, 8);
    endtask

    task automatic test_reset;
        bus.an  = 4'hF;
        bus.seg = 7'h00;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.value !== 16'h0000) begin fails++; $display("FAIL reset_value: got %h want 0000", bus.value); end
        tests++; if (bus.digit_err !== 4'h0) begin fails++; $display("FAIL reset_err: got %b want 0000", bus.digit_err); end
        tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.frame_valid); end
        tests++; if (bus.frame_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b want 0", bus.frame_abort); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 7'h00, 3);
    endtask

    task automatic test_basic;
        int v0, a0;
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h30, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'hB, 7'h79, 8);
        bus.an = 4'h7; bus.seg = 7'h33;
        repeat (4) @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early: got %b want 0", bus.frame_valid); end
        @(negedge clk);
        tests++; if (bus.frame_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_pulse: got %b want 1", bus.frame_valid); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL basic_value: got %h want 4321", bus.value); end
        repeat (3) @(negedge clk);
        drive(4'hF, 7'h00, 4);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL basic_valid_count: got %0d want 1", vcnt - v0); end
        tests++; if (acnt - a0 !== 0) begin fails++; $display("FAIL basic_abort_count: got %0d want 0", acnt - a0); end
        tests++; if (bus.digit_err !== 4'h0) begin fails++; $display("FAIL basic_err: got %b want 0000", bus.digit_err); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL basic_value_hold: got %h want 4321", bus.value); end
    endtask

    task automatic test_steady;
        int v0, a0;
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h5B, 30);
        drive(4'hD, 7'h5F, 8);
        drive(4'hB, 7'h70, 8);
        drive(4'h7, 7'h7F, 8);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL steady_valid_count: got %0d want 1", vcnt - v0); end
        tests++; if (acnt - a0 !== 0) begin fails++; $display("FAIL steady_abort_count: got %0d want 0", acnt - a0); end
        tests++; if (bus.value !== 16'h8765) begin fails++; $display("FAIL steady_value: got %h want 8765", bus.value); end
    endtask

    task automatic test_glitch;
        int v0, a0;
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h30, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'hB, 7'h7F, 3);
        drive(4'hB, 7'h79, 8);
        drive(4'h7, 7'h33, 8);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL glitch_valid_count: got %0d want 1", vcnt - v0); end
        tests++; if (acnt - a0 !== 0) begin fails++; $display("FAIL glitch_abort_count: got %0d want 0", acnt - a0); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL glitch_value: got %h want 4321", bus.value); end
    endtask

    task automatic test_bad_pattern;
        int v0;
        v0 = vcnt;
        scan4(7'h30, 7'h00, 7'h79, 7'h33);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL badpat_valid_count: got %0d want 1", vcnt - v0); end
        tests++; if (bus.value !== 16'h4301) begin fails++; $display("FAIL badpat_value: got %h want 4301", bus.value); end
        tests++; if (bus.digit_err !== 4'b0010) begin fails++; $display("FAIL badpat_err: got %b want 0010", bus.digit_err); end
    endtask

    task automatic test_out_of_order;
        int v0, a0;
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h30, 8);
        drive(4'hB, 7'h79, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'h7, 7'h33, 8);
        #1;
        tests++; if (acnt - a0 !== 1) begin fails++; $display("FAIL order_abort_count: got %0d want 1", acnt - a0); end
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL order_valid_count: got %0d want 0", vcnt - v0); end
        tests++; if (bus.value !== 16'h4301) begin fails++; $display("FAIL order_value_hold: got %h want 4301", bus.value); end
        tests++; if (bus.digit_err !== 4'b0010) begin fails++; $display("FAIL order_err_hold: got %b want 0010", bus.digit_err); end
        v0 = vcnt;
        scan4(7'h7E, 7'h5F, 7'h70, 7'h77);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL order_recover_count: got %0d want 1", vcnt - v0); end
        tests++; if (bus.value !== 16'hA760) begin fails++; $display("FAIL order_recover_value: got %h want a760", bus.value); end
        tests++; if (bus.digit_err !== 4'b0000) begin fails++; $display("FAIL order_recover_err: got %b want 0000", bus.digit_err); end
    endtask

    task automatic test_invalid_an;
        int v0, a0;
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h30, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'hC, 7'h79, 8);
        drive(4'h7, 7'h33, 8);
        #1;
        tests++; if (acnt - a0 !== 1) begin fails++; $display("FAIL multihot_abort_count: got %0d want 1", acnt - a0); end
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL multihot_valid_count: got %0d want 0", vcnt - v0); end
        v0 = vcnt; a0 = acnt;
        drive(4'hE, 7'h30, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'hF, 7'h00, 20);
        drive(4'hB, 7'h79, 8);
        drive(4'h7, 7'h33, 8);
        #1;
        tests++; if (acnt - a0 !== 0) begin fails++; $display("FAIL blank_abort_count: got %0d want 0", acnt - a0); end
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL blank_valid_count: got %0d want 1", vcnt - v0); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL blank_value: got %h want 4321", bus.value); end
    endtask

    task automatic test_reset_midframe;
        int v0, a0;
        drive(4'hE, 7'h30, 8);
        drive(4'hD, 7'h6D, 8);
        drive(4'hB, 7'h79, 8);
        rst_n = 1'b0;
        #1;
        tests++; if (bus.value !== 16'h0000) begin fails++; $display("FAIL midrst_value: got %h want 0000", bus.value); end
        tests++; if (bus.digit_err !== 4'h0) begin fails++; $display("FAIL midrst_err: got %b want 0000", bus.digit_err); end
        tests++; if (bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
            fails++; $display("FAIL midrst_strobes: got valid=%b abort=%b want 0/0", bus.frame_valid, bus.frame_abort);
        end
        @(negedge clk);
        @(negedge clk);
        v0 = vcnt; a0 = acnt;
        rst_n = 1'b1;
        drive(4'h7, 7'h33, 8);
        #1;
        tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL midrst_no_valid: got %0d want 0", vcnt - v0); end
        tests++; if (acnt - a0 !== 0) begin fails++; $display("FAIL midrst_no_abort: got %0d want 0", acnt - a0); end
        tests++; if (bus.value !== 16'h0000) begin fails++; $display("FAIL midrst_value_hold: got %h want 0000", bus.value); end
        v0 = vcnt;
        scan4(7'h30, 7'h6D, 7'h79, 7'h33);
        #1;
        tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL midrst_recover_count: got %0d want 1", vcnt - v0); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL midrst_recover_value: got %h want 4321", bus.value); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_steady();
        test_glitch();
        test_bad_pattern();
        test_out_of_order();
        test_invalid_an();
        test_reset_midframe();
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
